mem_access_arbiter: RTL and testbench
=====================================

# mem_access_arbiter

Two-port access controller that shares one small word-addressed memory between two requesters. Sequences each access through a fixed grant/response cycle, arbitrates round-robin when both request, and returns registered read data with a per-requester done pulse. Sits between two lab-level masters (e.g. a CPU fetch path and a test/debug port) and the memory array.

## Interface

Parameters:
- ADDR_WIDTH, 2, address bits; memory depth 2**ADDR_WIDTH words
- DATA_WIDTH, 4, bits per word

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  access request from requester 0 / 1, level, held until gnt
- we0 / we1  in  1  1 = write, 0 = read; valid while req high
- addr0 / addr1  in  ADDR_WIDTH  word address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, inputs may change next cycle
- done0 / done1  out  1  one-cycle pulse: access complete
- rdata  out  DATA_WIDTH  read data, valid only in the cycle a done pulse follows a read
- busy  out  1  high whenever the controller is not in IDLE

## Operation

- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req high, select winner, latch its we/addr/wdata and id, go to ACCESS. Else stay.
- ACCESS: gnt of latched id high. Read: array word at latched addr registered into rdata at end of cycle. Write: array word updated at end of cycle. Go to RESP.
- RESP: done of latched id high. Go to IDLE unconditionally.
- Arbitration: single req wins. Both high in IDLE: winner is the requester NOT granted last. Last-granted pointer updates on IDLE->ACCESS. After reset, pointer = 1, so requester 0 wins the first tie.
- Requests arriving during ACCESS/RESP wait; they are evaluated in the next IDLE cycle.
- rdata holds its last value between accesses; unchanged by writes.
- Memory initial contents (loaded by reset): word0 = 4'h4, word1 = 4'hC, word2 = 4'h6, word3 = 4'h7; any further words 0.
- Reset (any state): state -> IDLE, pointer -> 1, gnt0/gnt1/done0/done1/busy -> 0, rdata -> 0, memory reloaded. Reset in the ACCESS cycle of a write takes precedence: no write occurs.
- At most one of gnt0/gnt1 and one of done0/done1 high in any cycle.

## Timing

- req sampled in IDLE cycle N -> gnt in N+1 -> done and rdata in N+2 -> IDLE in N+3.
- Fixed latency, 3 cycles per access; sustained throughput one access per 3 cycles.
- busy high in N+1 and N+2.
- Requester inputs need only be stable in the sampling cycle N; dropping req after gnt does not cancel the access.

## Configuration

- MEM_WRITE_EN defined: writes performed as above; memory is a register array with reset-load.
- MEM_WRITE_EN undefined: memory is a constant combinational lookup of the initial contents; we0/we1 and wdata ignored, every access is a read, rdata returns the stored constant; handshake timing unchanged.

## Structure

- Package mem_arb_pkg: ADDR_WIDTH, DATA_WIDTH defaults, state enum type, initial-content constant array.
- Sub-module mem_array: storage plus init, one read and (under MEM_WRITE_EN) one write port; the arbiter holds FSM, pointer, latches and rdata register.

## Test plan

- Reset, then req0 read addr 1 -> gnt0 at cycle 1, done0 at cycle 2 with rdata = 4'hC, busy low at cycle 3.
- Reset, req0 read addr 2 and req1 read addr 3 together, both held -> gnt0 cycle 1, done0 cycle 2 rdata 4'h6; gnt1 cycle 4, done1 cycle 5 rdata 4'h7.
- MEM_WRITE_EN on: req1 write addr 0 data 4'h9, then req0 read addr 0 -> done0 with rdata 4'h9.
- MEM_WRITE_EN off: same sequence -> done1 pulses, subsequent read returns 4'h4.
- Reset asserted during ACCESS of write addr 3 data 4'h1 -> next cycle all outputs 0, state IDLE, later read addr 3 returns 4'h7.
- Both req held continuously for 4 accesses -> grant order 0, 1, 0, 1, never two gnt in same cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants, FSM state type and power-on memory image for mem_access_arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 2;
  localparam int unsigned DATA_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [DATA_WIDTH_DEFAULT-1:0] INIT_WORDS [4] = '{4'h4, 4'hC, 4'h6, 4'h7};

  // Words beyond the defined image read back as zero.
  function automatic logic [DATA_WIDTH_DEFAULT-1:0] init_word(input int unsigned idx);
    logic [31:0] i;
    i = idx;
    return (i < 32'd4) ? INIT_WORDS[i[1:0]] : '0;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Requester-side bus of mem_access_arbiter: two request channels plus shared response.
interface mem_access_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  done0;
  logic                  done1;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    output gnt0, gnt1, done0, done1, rdata, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1,
    input  gnt0, gnt1, done0, done1, rdata, busy
  );
endinterface

// File: rtl/mem_array.sv
// Word storage for mem_access_arbiter. MEM_WRITE_EN: writable register array reloaded on reset;
// otherwise a constant lookup of the power-on image.
module mem_array
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

`ifdef MEM_WRITE_EN
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  // Reset has priority, so a write in progress when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[ADDR_WIDTH'(i)] <= DATA_WIDTH'(init_word(i));
      end
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];
`else
  logic unused_wr;
  assign unused_wr = ^{clk, reset, we, wdata};

  always_comb begin
    rdata = DATA_WIDTH'(init_word(32'(addr)));
  end
`endif

endmodule

// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin access controller for a small word memory (IDLE/ACCESS/RESP).
// Optional write path enabled by defining MEM_WRITE_EN.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  mem_access_arbiter_if.slave bus
);
  state_e                state_q, state_d;
  logic                  id_q;
  logic                  last_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  any_req;
  logic                  win;
  logic                  accept;

`ifndef MEM_WRITE_EN
  logic unused_wr;
  assign unused_wr = ^{bus.we0, bus.we1, bus.wdata0, bus.wdata1};
  assign we_q      = 1'b0;
  assign wdata_q   = '0;
`endif

  assign any_req = bus.req0 | bus.req1;
  // On a tie the requester not granted last wins; a lone request always wins.
  assign win     = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  assign accept  = (state_q == StIdle) && any_req;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
`ifdef MEM_WRITE_EN
      we_q    <= 1'b0;
      wdata_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q   <= win;
        last_q <= win;
        addr_q <= win ? bus.addr1 : bus.addr0;
`ifdef MEM_WRITE_EN
        we_q    <= win ? bus.we1 : bus.we0;
        wdata_q <= win ? bus.wdata1 : bus.wdata0;
`endif
      end
      if (state_q == StAccess && !we_q) rdata_q <= mem_rdata;
    end
  end

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   ((state_q == StAccess) && we_q),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  assign bus.gnt0  = (state_q == StAccess) && !id_q;
  assign bus.gnt1  = (state_q == StAccess) && id_q;
  assign bus.done0 = (state_q == StResp) && !id_q;
  assign bus.done1 = (state_q == StResp) && id_q;
  assign bus.busy  = (state_q != StIdle);
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed self-checking bench for mem_access_arbiter (works with or without MEM_WRITE_EN).
module tb_mem_access_arbiter;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mem_access_arbiter_if #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) bus ();

  mem_access_arbiter #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {gnt0, gnt1, done0, done1, busy}
  function automatic logic [4:0] flags();
    return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (flags() !== 5'b00000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", flags());
    end
    n_checks++;
    if (bus.rdata !== 4'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    bus.req0 = 1; bus.addr0 = 2'd1;
    tick();
    n_checks++;
    if (flags() !== 5'b10001) begin
      n_fail++; $display("FAIL single_c1: got %b want 10001", flags());
    end
    bus.req0 = 0; bus.addr0 = 2'd3;
    tick();
    n_checks++;
    if (flags() !== 5'b00101 || bus.rdata !== 4'hC) begin
      n_fail++; $display("FAIL single_c2: got %b/%h want 00101/c", flags(), bus.rdata);
    end
    tick();
    n_checks++;
    if (flags() !== 5'b00000 || bus.rdata !== 4'hC) begin
      n_fail++; $display("FAIL single_c3: got %b/%h want 00000/c", flags(), bus.rdata);
    end
  endtask

  task automatic test_tie();
    logic [4:0] want [1:5];
    logic [3:0] want_rd [1:5];
    want    = '{5'b10001, 5'b00101, 5'b00000, 5'b01001, 5'b00011};
    want_rd = '{4'h0, 4'h6, 4'h6, 4'h6, 4'h7};
    do_reset();
    bus.req0 = 1; bus.addr0 = 2'd2;
    bus.req1 = 1; bus.addr1 = 2'd3;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) bus.req1 = 0;
      if (c >= 1) bus.req0 = 0;
      n_checks++;
      if (flags() !== want[c] || bus.rdata !== want_rd[c]) begin
        n_fail++;
        $display("FAIL tie_c%0d: got %b/%h want %b/%h", c, flags(), bus.rdata, want[c], want_rd[c]);
      end
    end
  endtask

  task automatic test_write_then_read();
    logic [3:0] exp_rd;
`ifdef MEM_WRITE_EN
    exp_rd = 4'h9;
`else
    exp_rd = 4'h4;
`endif
    do_reset();
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 2'd0; bus.wdata1 = 4'h9;
    tick();
    n_checks++;
    if (flags() !== 5'b01001) begin
      n_fail++; $display("FAIL wr_gnt1: got %b want 01001", flags());
    end
    bus.req1 = 0; bus.we1 = 0; bus.wdata1 = 4'h0;
    tick();
    n_checks++;
    if (flags() !== 5'b00011) begin
      n_fail++; $display("FAIL wr_done1: got %b want 00011", flags());
    end
    tick();
    bus.req0 = 1; bus.addr0 = 2'd0;
    tick();
    bus.req0 = 0;
    tick();
    n_checks++;
    if (flags() !== 5'b00101 || bus.rdata !== exp_rd) begin
      n_fail++; $display("FAIL wr_readback: got %b/%h want 00101/%h", flags(), bus.rdata, exp_rd);
    end
  endtask

  task automatic test_reset_during_write();
    do_reset();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 2'd3; bus.wdata0 = 4'h1;
    tick();
    n_checks++;
    if (flags() !== 5'b10001) begin
      n_fail++; $display("FAIL rst_wr_access: got %b want 10001", flags());
    end
    reset = 1; bus.req0 = 0; bus.we0 = 0;
    tick();
    n_checks++;
    if (flags() !== 5'b00000 || bus.rdata !== 4'h0) begin
      n_fail++; $display("FAIL rst_wr_outputs: got %b/%h want 00000/0", flags(), bus.rdata);
    end
    reset = 0;
    bus.req0 = 1; bus.addr0 = 2'd3;
    tick();
    bus.req0 = 0;
    tick();
    n_checks++;
    if (flags() !== 5'b00101 || bus.rdata !== 4'h7) begin
      n_fail++; $display("FAIL rst_wr_readback: got %b/%h want 00101/7", flags(), bus.rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want_rd [4];
    logic       want_id [4];
    int         n_gnt;
    want_id = '{1'b0, 1'b1, 1'b0, 1'b1};
    want_rd = '{4'h4, 4'hC, 4'h4, 4'hC};
    n_gnt = 0;
    do_reset();
    bus.req0 = 1; bus.addr0 = 2'd0;
    bus.req1 = 1; bus.addr1 = 2'd1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.gnt0 && bus.gnt1) begin
        n_fail++; $display("FAIL b2b_dual_gnt c%0d: got 11 want one-hot", c);
      end
      if (c % 3 == 1) begin
        n_checks++;
        if ({bus.gnt0, bus.gnt1} !== (want_id[n_gnt] ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL b2b_gnt%0d: got %b want id %0d", n_gnt, {bus.gnt0, bus.gnt1}, want_id[n_gnt]);
        end
      end
      if (c % 3 == 2) begin
        n_checks++;
        if (bus.rdata !== want_rd[n_gnt]) begin
          n_fail++; $display("FAIL b2b_rdata%0d: got %h want %h", n_gnt, bus.rdata, want_rd[n_gnt]);
        end
        n_gnt++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_write_then_read();
    test_reset_during_write();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
